// File: rtl/gouram_trace_drain_if.sv
// Word stream from the trace drain toward the trace sink (UART/DMA bridge).
// Latency: none, this only bundles wires.
// Backpressure: the sink throttles with out_ready; the source holds out_valid/out_data/out_last until accepted.
interface gouram_trace_drain_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/gouram_trace_drain.sv
// Buffers 128-bit tracer records in a small FIFO and serialises each as four 32-bit words, LSW first.
// Latency: strobe in cycle N gives word 0 valid in N+2 from empty/idle; one word per cycle sustained.
// Backpressure: a sink stall holds the current word; a full FIFO drops and counts records, never stalling the tracer.
module gouram_trace_drain #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trace_valid_i,
  input  logic [127:0]          trace_data_i,
  input  logic                  enable_i,
  input  logic                  flush_i,
  gouram_trace_drain_if.master  sink,
  output logic [CW-1:0]         fifo_count,
  output logic [15:0]           overflow_cnt,
  output logic                  busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state, state_n;
  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [127:0]  hold;
  logic [1:0]    word_idx;
  logic          full, empty, push, drop, pop, accept;

  // Full is judged on the pre-edge count, so a push is refused at full even if a pop happens this cycle.
  assign full   = (fifo_count == CW'(DEPTH));
  assign empty  = (fifo_count == '0);
  assign accept = (state == SEND) && sink.out_ready;
  assign push   = trace_valid_i && !full && !flush_i;
  assign drop   = trace_valid_i && full && !flush_i;
  assign pop    = enable_i && !empty && !flush_i &&
                  ((state == IDLE) || (accept && (word_idx == 2'd3)));

  // Record storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= trace_data_i;
  end

  // Pointers and occupancy; flush empties the queue but leaves the record in flight alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // Saturating drop counter; strobes during a flush are discarded silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_cnt <= '0;
    end else if (drop && (overflow_cnt != 16'hFFFF)) begin
      overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

  // Hold register and word index: a pop reloads both, each accepted word advances the index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold     <= '0;
      word_idx <= '0;
    end else if (pop) begin
      hold     <= mem[rd_ptr];
      word_idx <= '0;
    end else if (accept) begin
      word_idx <= word_idx + 2'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state: stay in SEND across back-to-back records, fall to IDLE when the last word leaves with nothing to pop.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pop) state_n = SEND;
      SEND:    if (accept && (word_idx == 2'd3) && !pop) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs decode registered state only; nothing here depends on out_ready.
  assign sink.out_valid = (state == SEND);
  assign sink.out_last  = (state == SEND) && (word_idx == 2'd3);
  assign sink.out_data  = (state == SEND) ? hold[{word_idx, 5'd0} +: 32] : 32'd0;
  assign busy           = (state == SEND) || !empty;

endmodule

// File: tb/tb_gouram_trace_drain.sv
// Self-checking bench for gouram_trace_drain: a queue-based record model is compared every cycle,
// directed scenarios pin the model with literal expectations, then randomized traffic runs.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_gouram_trace_drain;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           trace_valid_i = 1'b0;
  logic [127:0]   trace_data_i = '0;
  logic           enable_i = 1'b0;
  logic           flush_i = 1'b0;
  logic [CW-1:0]  fifo_count;
  logic [15:0]    overflow_cnt;
  logic           busy;

  gouram_trace_drain_if sink_if ();

  gouram_trace_drain #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .trace_valid_i (trace_valid_i),
    .trace_data_i  (trace_data_i),
    .enable_i      (enable_i),
    .flush_i       (flush_i),
    .sink          (sink_if),
    .fifo_count    (fifo_count),
    .overflow_cnt  (overflow_cnt),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: a queue of stored records plus the record on the wire and how many words remain.
  logic [127:0] mq[$];
  logic [127:0] m_cur  = '0;
  bit           m_send = 1'b0;
  int           m_left = 0;
  int           m_ovf  = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq.delete();
      m_send = 1'b0;
      m_left = 0;
      m_ovf  = 0;
    end else begin
      bit was_full, can_take, do_pop;
      was_full = (mq.size() == DEPTH);
      can_take = !m_send || (sink_if.out_ready && m_left == 1);
      do_pop   = enable_i && (mq.size() != 0) && !flush_i && can_take;
      if (m_send && sink_if.out_ready) begin
        m_left--;
        if (m_left == 0) m_send = 1'b0;
      end
      if (do_pop) begin
        m_cur  = mq.pop_front();
        m_send = 1'b1;
        m_left = 4;
      end
      if (flush_i) mq.delete();
      else if (trace_valid_i) begin
        if (was_full) begin
          if (m_ovf < 65535) m_ovf++;
        end else begin
          mq.push_back(trace_data_i);
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of accepted words for the directed checks.
  bit          chk_en = 1'b1;
  int          cyc = 0;
  logic [31:0] got_w[$];
  bit          got_l[$];
  int          got_c[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    if (chk_en) begin
      chk("out_valid", sink_if.out_valid, m_send);
      if (m_send) chk("out_data", sink_if.out_data, m_cur[32*(4-m_left) +: 32]);
      chk("out_last", sink_if.out_last, m_send && (m_left == 1));
      chk("fifo_count", fifo_count, mq.size());
      chk("overflow_cnt", overflow_cnt, m_ovf);
      chk("busy", busy, m_send || (mq.size() != 0));
    end
    if (sink_if.out_valid && sink_if.out_ready) begin
      got_w.push_back(sink_if.out_data);
      got_l.push_back(sink_if.out_last);
      got_c.push_back(cyc);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [127:0] d);
    trace_valid_i = 1'b1;
    trace_data_i  = d;
    step();
    trace_valid_i = 1'b0;
  endtask

  task automatic clear_log();
    got_w.delete();
    got_l.delete();
    got_c.delete();
  endtask

  // Record i carries word k = (k+1)<<28 + i, so order and identity are both visible.
  function automatic logic [127:0] rec(input int i);
    return {32'h4000_0000 + 32'(i), 32'h3000_0000 + 32'(i),
            32'h2000_0000 + 32'(i), 32'h1000_0000 + 32'(i)};
  endfunction

  function automatic logic [31:0] rec_word(input int i, input int k);
    return 32'((k + 1) << 28) + 32'(i);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit found;
    logic [127:0] basic = 128'h44444444_33333333_22222222_11111111;
    sink_if.out_ready = 1'b1;

    // Reset state
    step(2);
    chk("rst_valid", sink_if.out_valid, 1'b0);
    chk("rst_data", sink_if.out_data, 32'd0);
    chk("rst_last", sink_if.out_last, 1'b0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ovf", overflow_cnt, 0);
    chk("rst_busy", busy, 1'b0);

    // Basic record: latency and word order
    rst = 1'b0;
    enable_i = 1'b1;
    step();
    clear_log();
    strobe(basic);
    chk("lat_count_n1", fifo_count, 1);
    chk("lat_valid_n1", sink_if.out_valid, 1'b0);
    step();
    chk("lat_valid_n2", sink_if.out_valid, 1'b1);
    chk("lat_word0", sink_if.out_data, 32'h11111111);
    step(3);
    chk("basic_last_w3", sink_if.out_last, 1'b1);
    step();
    chk("basic_busy_fall", busy, 1'b0);
    chk("basic_nwords", got_w.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk("basic_word", got_w[k], 32'(32'h11111111 * (k + 1)));
      chk("basic_lastflag", got_l[k], k == 3);
    end

    // Backpressure during word 1
    clear_log();
    strobe(basic);
    step(2);
    sink_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", sink_if.out_valid, 1'b1);
      chk("bp_data", sink_if.out_data, 32'h22222222);
      step();
    end
    sink_if.out_ready = 1'b1;
    step(5);
    chk("bp_nwords", got_w.size(), 4);
    for (int k = 0; k < 4; k++) chk("bp_word", got_w[k], 32'(32'h11111111 * (k + 1)));

    // Overflow with draining disabled, then back-to-back drain
    enable_i = 1'b0;
    clear_log();
    for (int i = 0; i < DEPTH + 3; i++) begin
      trace_valid_i = 1'b1;
      trace_data_i  = rec(i);
      step();
    end
    trace_valid_i = 1'b0;
    chk("ovf_count_full", fifo_count, 8);
    chk("ovf_cnt3", overflow_cnt, 3);
    enable_i = 1'b1;
    step(40);
    chk("ovf_nwords", got_w.size(), 32);
    for (int r = 0; r < DEPTH; r++)
      for (int k = 0; k < 4; k++)
        chk("ovf_word", got_w[r*4+k], rec_word(r, k));
    chk("ovf_b2b_span", got_c[31] - got_c[0], 31);

    // Strobe dropped in the same cycle word 3 is accepted and the next record pops
    enable_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) strobe(rec(100 + i));
    enable_i = 1'b1;
    step();
    strobe(rec(200));
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (sink_if.out_last) found = 1'b1;
      else step();
    end
    chk("pp_found_last", found, 1'b1);
    chk("pp_count_before", fifo_count, 8);
    trace_valid_i = 1'b1;
    trace_data_i  = rec(300);
    step();
    trace_valid_i = 1'b0;
    chk("pp_ovf", overflow_cnt, 4);
    chk("pp_count_after", fifo_count, 7);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (!busy) found = 1'b1;
      else step();
    end
    chk("pp_drain_done", found, 1'b1);

    // Flush while sending A with three records queued
    enable_i = 1'b0;
    for (int i = 0; i < 4; i++) strobe(rec(500 + i));
    clear_log();
    enable_i = 1'b1;
    step();
    chk("fl_count_pre", fifo_count, 3);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("fl_count", fifo_count, 0);
    step(8);
    chk("fl_nwords", got_w.size(), 4);
    for (int k = 0; k < 4; k++) chk("fl_word", got_w[k], rec_word(500, k));
    chk("fl_ovf", overflow_cnt, 4);
    chk("fl_valid", sink_if.out_valid, 1'b0);

    // Reset asserted mid-word-2
    strobe(rec(600));
    step(3);
    chk("rr_word2", sink_if.out_data, rec_word(600, 2));
    rst = 1'b1;
    #1;
    chk("rr_valid", sink_if.out_valid, 1'b0);
    chk("rr_data", sink_if.out_data, 32'd0);
    chk("rr_last", sink_if.out_last, 1'b0);
    chk("rr_count", fifo_count, 0);
    chk("rr_ovf", overflow_cnt, 0);
    chk("rr_busy", busy, 1'b0);
    step(2);
    rst = 1'b0;
    step(6);
    chk("rr_no_reemit", sink_if.out_valid, 1'b0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      trace_valid_i     = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
      trace_data_i      = {$urandom, $urandom, $urandom, $urandom};
      enable_i          = ($urandom_range(0, 9) != 0);
      flush_i           = ($urandom_range(0, 99) == 0);
      sink_if.out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    trace_valid_i     = 1'b0;
    flush_i           = 1'b0;
    enable_i          = 1'b1;
    sink_if.out_ready = 1'b1;
    step(100);
    chk("rand_idle", busy, 1'b0);

    // Saturation of the drop counter
    rst = 1'b1;
    step();
    rst = 1'b0;
    enable_i = 1'b0;
    chk_en = 1'b0;
    trace_valid_i = 1'b1;
    step(DEPTH + 65535);
    chk("sat_reach", overflow_cnt, 16'hFFFF);
    chk("sat_count", fifo_count, 8);
    step(5);
    chk("sat_hold", overflow_cnt, 16'hFFFF);
    trace_valid_i = 1'b0;
    chk_en = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/gouram_trace_drain.md
# gouram_trace_drain

Buffers 128-bit trace records from the gouram tracer in a small FIFO and serialises each record into four 32-bit words on a valid/ready stream toward the trace sink (debug UART/DMA bridge). It sits between the tracer's `trace_data_o` and the narrower sink bus, and it decouples tracer bursts from sink backpressure. When the FIFO is full it drops records and counts them, so the tracer is never stalled.

## Interface
- `DEPTH`, 8: FIFO depth in records; a power of two, minimum 2.
- `CW`, $clog2(DEPTH)+1: width of the occupancy count.
- `clk`  in  1  sole clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `trace_valid_i`  in  1  one-cycle strobe; `trace_data_i` holds a new record.
- `trace_data_i`  in  128  trace record from the tracer.
- `enable_i`  in  1  permits new records to be popped for draining.
- `flush_i`  in  1  synchronous FIFO clear.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  the sink accepts the word.
- `out_data`  out  32  current word of the record.
- `out_last`  out  1  high on word 3 of a record.
- `fifo_count`  out  CW  records stored; excludes the record being sent.
- `overflow_cnt`  out  16  records dropped; saturates at 0xFFFF.
- `busy`  out  1  high when a record is being sent or `fifo_count` != 0.

## Operation
- **FIFO:** circular buffer with write and read pointers that wrap modulo DEPTH, plus an occupancy counter.
- **Push:** occurs when `trace_valid_i` && !full && !`flush_i`. Full is judged on the pre-edge `fifo_count == DEPTH`. A push is therefore refused when full even if a pop happens in the same cycle.
- **Drop:** `trace_valid_i` && full && !`flush_i` increments `overflow_cnt`, saturating. A strobe during `flush_i` is discarded and not counted.
- **Pop:** occurs when `enable_i` && !empty && !`flush_i` && (state==IDLE || (state==SEND && word_idx==3 && `out_ready`)). The popped entry loads the 128-bit hold register and sets word_idx to 0.
- **Simultaneous push and pop** (FIFO not full): the count is unchanged and both pointers advance.
- **FSM states:**
  - IDLE: `out_valid`=0. Moves to SEND on a pop.
  - SEND: `out_valid`=1 and `out_data` = hold[32*word_idx +: 32], so the least-significant word goes first. On `out_valid`&&`out_ready`, word_idx increments.
  - On acceptance of word 3: stay in SEND with the next record if a pop occurs; otherwise go to IDLE.
- **Data stability:** while `out_valid` && !`out_ready`, `out_data` and `out_last` hold stable. `out_valid` never drops before acceptance.
- **`out_last`** = (state==SEND && word_idx==3).
- **`enable_i` low:** the record in flight still completes; no further pops occur. Pushes continue.
- **`flush_i`:**
  - Pointers and count go to 0 on the next edge.
  - A record in SEND completes normally from the hold register.
  - `overflow_cnt` is unaffected.
- **Reset:**
  - Asynchronous clear of pointers, count, `overflow_cnt`, word_idx, hold register and FSM (to IDLE).
  - Outputs after reset: `out_valid`=0, `out_data`=0, `out_last`=0, `fifo_count`=0, `overflow_cnt`=0, `busy`=0.
  - Reset asserted mid-record abandons the record; no partial word is re-emitted after release.

## Timing
- **Latency from empty and IDLE with `enable_i`=1:**
  - strobe in cycle N;
  - `fifo_count`=1 in N+1 (pop at end of N+1);
  - `out_valid`=1 with word 0 in N+2.
- **Throughput:** with `out_ready` held high, one word per cycle. Records stream back-to-back with no idle cycle between word 3 and the next word 0.
- **Minimum record duration:** 4 cycles. Sustained tracer rate must be ≤ 1 record per 4 cycles to avoid drops.
- **Output registering:** all outputs are registered, or decoded from registered state only. `out_valid` has no combinational path from `out_ready`.
- **`busy`** goes low in the cycle after word 3 is accepted, provided the FIFO is empty.

## Test plan
- **Basic record:** reset, then one strobe with data 0x44444444_33333333_22222222_11111111, `out_ready`=1. Required:
  - `out_valid` rises 2 cycles after the strobe;
  - words emitted 0x11111111, 0x22222222, 0x33333333, 0x44444444;
  - `out_last` high only on the 4th word;
  - `busy` falls the next cycle.
- **Backpressure:** same record; `out_ready` low for 3 cycles during word 1. Required: `out_data`=0x22222222 held stable with `out_valid` high throughout; the remaining words follow in order.
- **Overflow:** `enable_i`=0 and DEPTH+3=11 strobes on consecutive cycles. Required:
  - `fifo_count`=8 and `overflow_cnt`=3;
  - after setting `enable_i`=1, exactly 8 records drain in order, back-to-back (32 consecutive accepted words).
- **Simultaneous push/pop at full:** FIFO full, strobe in the same cycle that word 3 is accepted and the next record pops. Required: the strobe is dropped, `overflow_cnt` increments by 1, and `fifo_count` goes 8→7.
- **Flush and reset:**
  - `flush_i` while sending record A with 3 records queued: A completes, `fifo_count`=0, nothing further is emitted, `overflow_cnt` is unchanged.
  - Separately, assert `rst` mid-word-2: all outputs are 0 immediately.
- **Saturation:** force 65540 drops. Required: `overflow_cnt` holds at 0xFFFF.
